// File: rtl/dest_rr_merge.sv
// rtl/dest_rr_merge.sv - round-robin merge of two destination FIFOs into one stream
//
// Purpose: pops two upstream FIFOs (D0, D1) in round-robin order. It merges the
// returned words onto a single registered output. A one-entry skid buffer absorbs
// the word still in flight when downstream stalls. Protocol violations on the read
// return path are detected and trap the block in a sticky ERROR state.
//
// Ports:
//   clk                  clock, rising edge
//   reset                asynchronous active-low reset
//   init                 synchronous re-initialise request
//   empty_0/1            upstream FIFO empty flags
//   data_in_0/1 [5:0]    upstream FIFO read data
//   valid_in_0/1         read data valid, one cycle after the matching pop
//   stall_in             downstream back-pressure
//   pop_0/1              pop requests (combinational, never both high)
//   data_out [5:0]       merged output word (holds when valid_out=0)
//   valid_out            one-cycle strobe per delivered word
//   count_0/1 [4:0]      words delivered per source, wrapping
//   idle_out/active_out/error_out  registered state decodes

module dest_rr_merge (
  input  logic       clk,
  input  logic       reset,
  input  logic       init,
  input  logic       empty_0,
  input  logic       empty_1,
  input  logic [5:0] data_in_0,
  input  logic [5:0] data_in_1,
  input  logic       valid_in_0,
  input  logic       valid_in_1,
  input  logic       stall_in,
  output logic       pop_0,
  output logic       pop_1,
  output logic [5:0] data_out,
  output logic       valid_out,
  output logic [4:0] count_0,
  output logic [4:0] count_1,
  output logic       idle_out,
  output logic       active_out,
  output logic       error_out
);

  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_INIT   = 3'd1,
    S_IDLE   = 3'd2,
    S_ACTIVE = 3'd3,
    S_ERROR  = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic       idle_q, idle_d;
  logic       active_q, active_d;
  logic       error_q, error_d;

  // last_q = 1 means D1 was granted last, so D0 wins the next contested grant
  logic       last_q, last_d;
  logic       pop0_prev_q, pop0_prev_d;
  logic       pop1_prev_q, pop1_prev_d;
  logic       skid_full_q, skid_full_d;
  logic [5:0] skid_data_q, skid_data_d;
  logic       skid_src_q, skid_src_d;
  logic [5:0] data_out_q, data_out_d;
  logic       valid_out_q, valid_out_d;
  logic [4:0] count_0_q, count_0_d;
  logic [4:0] count_1_q, count_1_d;

  logic       violation;
  logic       can_pop;
  logic       accept;
  logic       arriving;
  logic [5:0] in_data;
  logic       in_src;

  // A return word is only legal as the answer to our own pop one cycle earlier.
  assign violation = (valid_in_0 & valid_in_1) |
                     (valid_in_0 & ~pop0_prev_q) |
                     (valid_in_1 & ~pop1_prev_q);

  // ---------------- state register ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_RESET;
      idle_q   <= 1'b0;
      active_q <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      idle_q   <= idle_d;
      active_q <= active_d;
      error_q  <= error_d;
    end
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    state_d = state_q;
    if (init) begin
      state_d = S_INIT;
    end else if (violation) begin
      state_d = S_ERROR;
    end else begin
      case (state_q)
        S_RESET:  state_d = S_RESET;
        S_INIT:   state_d = S_IDLE;
        S_IDLE:   if (!empty_0 || !empty_1) state_d = S_ACTIVE;
        S_ACTIVE: if (empty_0 && empty_1 && !skid_full_q &&
                      !pop0_prev_q && !pop1_prev_q) state_d = S_IDLE;
        S_ERROR:  state_d = S_ERROR;
        default:  state_d = S_RESET;
      endcase
    end
  end

  // ---------------- output logic ----------------
  // Pops need a free path to the output: no stall and an empty skid, so a
  // returning word can always be either delivered or parked.
  always_comb begin
    can_pop  = (state_q == S_ACTIVE) && !init && !stall_in && !skid_full_q;
    pop_0    = can_pop && !empty_0 && (empty_1 || last_q);
    pop_1    = can_pop && !empty_1 && (empty_0 || !last_q);
    // Decode the next state so the registered flags line up with state_q.
    idle_d   = (state_d == S_IDLE);
    active_d = (state_d == S_ACTIVE);
    error_d  = (state_d == S_ERROR);
  end

  // ---------------- datapath ----------------
  always_comb begin
    last_d      = last_q;
    pop0_prev_d = pop_0;
    pop1_prev_d = pop_1;
    skid_full_d = skid_full_q;
    skid_data_d = skid_data_q;
    skid_src_d  = skid_src_q;
    data_out_d  = data_out_q;
    valid_out_d = 1'b0;
    count_0_d   = count_0_q;
    count_1_d   = count_1_q;

    arriving = valid_in_0 | valid_in_1;
    in_data  = valid_in_1 ? data_in_1 : data_in_0;
    in_src   = valid_in_1;
    accept   = (state_q == S_ACTIVE) && !init && !violation;

    if (pop_0) last_d = 1'b0;
    if (pop_1) last_d = 1'b1;

    if (init) begin
      // Anything in flight or parked is discarded.
      skid_full_d = 1'b0;
      count_0_d   = 5'd0;
      count_1_d   = 5'd0;
    end else if (accept) begin
      if (skid_full_q) begin
        // No pop was issued while the skid was full, so nothing can arrive now.
        if (!stall_in) begin
          skid_full_d = 1'b0;
          data_out_d  = skid_data_q;
          valid_out_d = 1'b1;
          if (skid_src_q) count_1_d = count_1_q + 5'd1;
          else            count_0_d = count_0_q + 5'd1;
        end
      end else if (arriving) begin
        if (stall_in) begin
          skid_full_d = 1'b1;
          skid_data_d = in_data;
          skid_src_d  = in_src;
        end else begin
          data_out_d  = in_data;
          valid_out_d = 1'b1;
          if (in_src) count_1_d = count_1_q + 5'd1;
          else        count_0_d = count_0_q + 5'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_q      <= 1'b1;
      pop0_prev_q <= 1'b0;
      pop1_prev_q <= 1'b0;
      skid_full_q <= 1'b0;
      skid_data_q <= 6'd0;
      skid_src_q  <= 1'b0;
      data_out_q  <= 6'd0;
      valid_out_q <= 1'b0;
      count_0_q   <= 5'd0;
      count_1_q   <= 5'd0;
    end else begin
      last_q      <= last_d;
      pop0_prev_q <= pop0_prev_d;
      pop1_prev_q <= pop1_prev_d;
      skid_full_q <= skid_full_d;
      skid_data_q <= skid_data_d;
      skid_src_q  <= skid_src_d;
      data_out_q  <= data_out_d;
      valid_out_q <= valid_out_d;
      count_0_q   <= count_0_d;
      count_1_q   <= count_1_d;
    end
  end

  assign data_out   = data_out_q;
  assign valid_out  = valid_out_q;
  assign count_0    = count_0_q;
  assign count_1    = count_1_q;
  assign idle_out   = idle_q;
  assign active_out = active_q;
  assign error_out  = error_q;

endmodule

// File: doc/dest_rr_merge.md
DEST_RR_MERGE -- requirements
Module: dest_rr_merge

Interface
REQ-001 The block SHALL have a single clock, clk, and all flops SHALL update on its rising edge.
REQ-002 Reset SHALL be asynchronous and active-low, port reset; reset=0 forces all state and outputs to reset values immediately.
REQ-003 Ports SHALL be, one per line (name, direction, width, meaning):
  clk  in  1  clock
  reset  in  1  async active-low reset
  init  in  1  synchronous re-initialise request
  empty_0  in  1  destination FIFO D0 empty flag
  empty_1  in  1  destination FIFO D1 empty flag
  data_in_0  in  6  D0 FIFO read data
  data_in_1  in  6  D1 FIFO read data
  valid_in_0  in  1  data_in_0 valid, one cycle after pop_0
  valid_in_1  in  1  data_in_1 valid, one cycle after pop_1
  stall_in  in  1  downstream back-pressure
  pop_0  out  1  pop request to D0 FIFO
  pop_1  out  1  pop request to D1 FIFO
  data_out  out  6  merged output word
  valid_out  out  1  data_out valid, one cycle per word
  count_0  out  5  words delivered from D0
  count_1  out  5  words delivered from D1
  idle_out  out  1  high in IDLE
  active_out  out  1  high in ACTIVE
  error_out  out  1  high in ERROR

Function
REQ-004 States SHALL be RESET, INIT, IDLE, ACTIVE, ERROR, held in a registered state variable.
REQ-005 Transitions: RESET->INIT on init=1; INIT->IDLE on init=0; IDLE->ACTIVE when empty_0=0 or empty_1=0; ACTIVE->IDLE when both empty, skid empty, no pop in flight; any state except RESET->INIT on init=1; any state->ERROR on a protocol violation.
REQ-006 Protocol violation: valid_in_0 and valid_in_1 high in the same cycle, or valid_in_x high without pop_x in the previous cycle.
REQ-007 ERROR SHALL be sticky until init=1 or reset=0.
REQ-008 pop_0 and pop_1 SHALL never be high in the same cycle; at most one pop per cycle.
REQ-009 A pop SHALL be issued only when state=ACTIVE, stall_in=0, the skid buffer is empty, and the selected FIFO is non-empty; pops are combinational from registered state and current inputs.
REQ-010 Round-robin selection: if both non-empty, grant the FIFO not granted last; if only one non-empty, grant it; the last-grant pointer updates only on an issued pop and resets to 1, so D0 wins first.
REQ-011 A word arriving in cycle N with stall_in=0 and the skid empty SHALL appear on data_out with valid_out=1 in cycle N+1; total pop-to-output latency is 2 cycles.
REQ-012 A word arriving with stall_in=1 SHALL be captured in a one-entry skid buffer; no word is ever dropped.
REQ-013 With the skid full and stall_in=0, the skid entry SHALL drain to data_out in the next cycle; no pop is issued in the draining cycle.
REQ-014 valid_out SHALL be 0 in every cycle without a delivered word; data_out holds its last value.
REQ-015 count_x SHALL increment by 1 on each delivered D_x word, wrapping 31->0, and clear on init=1.
REQ-016 An init asserted with a word in flight or in the skid SHALL discard that word; no pop occurs while init=1.
REQ-017 No pops SHALL be issued in RESET, INIT, IDLE or ERROR.
REQ-018 idle_out, active_out and error_out SHALL be registered decodes of state, mutually exclusive.

Reset
REQ-019 Under reset=0: state=RESET, pop_0=pop_1=0, data_out=0, valid_out=0, count_0=count_1=0, idle_out=active_out=error_out=0, skid empty, last-grant=1.
REQ-020 A reset asserted mid-transfer SHALL abort it; the in-flight word is lost, and the upstream FIFOs are reset by the same signal.

Verification
REQ-021 Reset then init pulse, both empty -> idle_out=1, pops stay 0, counts 0.
REQ-022 D0 holds 0x01, 0x11 and D1 holds 0x22, 0x33, stall_in=0 -> data_out sequence 0x01, 0x22, 0x11, 0x33 on consecutive pop cycles; count_0=2, count_1=2; then IDLE.
REQ-023 Only D1 non-empty with 3 words -> pop_1 on 3 consecutive cycles, valid_out high for 3 cycles starting 2 cycles after the first pop.
REQ-024 stall_in raised the cycle after a pop_0 of 0x15 and held 4 cycles -> no pops and valid_out=0 during the stall; 0x15 is delivered the cycle after stall_in falls; count_0=1.
REQ-025 valid_in_0 and valid_in_1 forced high together -> error_out=1 next cycle and held; an init pulse returns to INIT then IDLE with counts cleared.
REQ-026 32 words from D0 -> count_0 wraps to 0; reset=0 asserted mid-stream -> all outputs are 0 immediately.
